// File: rtl/read_status_logic_if.sv
// Read-side status bus: write-stage strobe, consumer read request, thresholds in;
// qualified pop, read address, occupancy and status/error flags out.
interface read_status_logic_if #(
  parameter int PTR_L = 3,
  parameter int CNT_L = 3
);
  logic             push;
  logic             fifo_rd;
  logic [CNT_L-1:0] almost_full_th;
  logic [CNT_L-1:0] almost_empty_th;
  logic             pop;
  logic [PTR_L-1:0] rd_ptr;
  logic [CNT_L-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow_err;
  logic             underflow_err;
  logic [1:0]       state;

  modport slave (
    input  push, fifo_rd, almost_full_th, almost_empty_th,
    output pop, rd_ptr, fifo_count, fifo_full, fifo_empty,
           almost_full, almost_empty, overflow_err, underflow_err, state
  );

  modport master (
    output push, fifo_rd, almost_full_th, almost_empty_th,
    input  pop, rd_ptr, fifo_count, fifo_full, fifo_empty,
           almost_full, almost_empty, overflow_err, underflow_err, state
  );
endinterface

// File: rtl/read_status_logic.sv
// FIFO read pointer, occupancy and status flags; pop is combinational, count/ptr update next edge.
// Backpressure: fifo_full stalls the write stage (held high in INIT); reads on empty are refused.
module read_status_logic #(
  parameter int MEM_SIZE = 4,
  parameter int PTR_L    = 3,
  parameter int CNT_L    = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  read_status_logic_if.slave   bus
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_L-1:0] r_count;
  logic [CNT_L-1:0] w_count_nxt;
  logic [CNT_L-1:0] r_af_th;
  logic [CNT_L-1:0] r_ae_th;
  logic [PTR_L-1:0] r_rd_ptr;
  logic             r_ovf;
  logic             r_unf;
  logic             w_init;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_pop;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_state <= INIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_init      = (r_state == INIT);
    // INIT reports full and empty so neither side moves until thresholds are latched
    w_full      = w_init | (r_count == CNT_L'(MEM_SIZE));
    w_empty     = w_init | (r_count == '0);
    w_pop       = bus.fifo_rd & ~w_empty;
    w_wr        = bus.push & ~w_full;
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    if (w_wr && !w_pop)      w_count_nxt = r_count + CNT_L'(1);
    else if (w_pop && !w_wr) w_count_nxt = r_count - CNT_L'(1);
    case (r_state)
      INIT:    w_state_nxt = IDLE;
      IDLE:    if (w_count_nxt != '0) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_count_nxt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_af_th  <= '0;
      r_ae_th  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_pop) begin
        if (r_rd_ptr == PTR_L'(MEM_SIZE - 1)) r_rd_ptr <= '0;
        else                                  r_rd_ptr <= r_rd_ptr + PTR_L'(1);
      end
      if (w_init) begin
        r_af_th <= bus.almost_full_th;
        r_ae_th <= bus.almost_empty_th;
      end
      if (!w_init && bus.push && w_full)     r_ovf <= 1'b1;
      if (!w_init && bus.fifo_rd && w_empty) r_unf <= 1'b1;
    end
  end

  assign bus.pop           = w_pop;
  assign bus.rd_ptr        = r_rd_ptr;
  assign bus.fifo_count    = r_count;
  assign bus.fifo_full     = w_full;
  assign bus.fifo_empty    = w_empty;
  assign bus.almost_full   = ~w_init & (r_count >= r_af_th);
  assign bus.almost_empty  = ~w_init & (r_count <= r_ae_th);
  assign bus.overflow_err  = r_ovf;
  assign bus.underflow_err = r_unf;
  assign bus.state         = r_state;

endmodule
